// File: rtl/seq_gen_ctrl.sv
// Run controller for the indirect-logic sequence generators: latches a pattern
// and run length on start, then emits one pattern bit per clock until done/stop.
module seq_gen_ctrl #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic [1:0]       mode,
    input  logic [LEN_W-1:0] len,
    output logic             f,
    output logic             f_vld,
    output logic [2:0]       q,
    output logic [LEN_W-1:0] cnt,
    output logic             busy,
    output logic             done,
    output logic             abort
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q;
    logic [1:0]       mode_q;
    logic [LEN_W-1:0] len_q;
    logic [2:0]       q_q;
    logic [LEN_W-1:0] cnt_q;
    logic             f_q;
    logic             f_vld_q;
    logic             busy_q;
    logic             done_q;
    logic             abort_q;

    logic [2:0]       q_d;
    logic [LEN_W-1:0] cnt_d;
    logic             f_d;

    // Bit i of the returned table is the pattern bit for state index i.
    function automatic logic pat_bit(input logic [1:0] m, input logic [2:0] idx);
        logic [7:0] bits;
        case (m)
            2'd0:    bits = 8'b0000_1101;
            2'd1:    bits = 8'b0000_1011;
            2'd2:    bits = 8'b0000_0001;
            default: bits = 8'b0010_0111;
        endcase
        return bits[idx];
    endfunction

    function automatic logic [2:0] pat_last(input logic [1:0] m);
        case (m)
            2'd0:    return 3'd4;
            2'd1:    return 3'd5;
            2'd2:    return 3'd3;
            default: return 3'd6;
        endcase
    endfunction

    // Next emitted bit when the run advances; wraps at the same edge.
    always_comb begin
        q_d   = (q_q == pat_last(mode_q)) ? 3'd0 : q_q + 3'd1;
        cnt_d = cnt_q + 1'b1;
        f_d   = pat_bit(mode_q, q_d);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            mode_q  <= 2'd0;
            len_q   <= '0;
            q_q     <= 3'd0;
            cnt_q   <= '0;
            f_q     <= 1'b0;
            f_vld_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    f_vld_q <= 1'b0;
                    if (start && !stop) begin
                        state_q <= RUN;
                        mode_q  <= mode;
                        len_q   <= len;
                        q_q     <= 3'd0;
                        cnt_q   <= LEN_W'(1);
                        f_q     <= pat_bit(mode, 3'd0);
                        f_vld_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_q <= IDLE;
                        abort_q <= 1'b1;
                        busy_q  <= 1'b0;
                        f_vld_q <= 1'b0;
                    end else if ((len_q != '0) && (cnt_q == len_q)) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        f_vld_q <= 1'b0;
                    end else if (pause) begin
                        state_q <= PAUSE;
                        f_vld_q <= 1'b0;
                    end else begin
                        q_q     <= q_d;
                        cnt_q   <= cnt_d;
                        f_q     <= f_d;
                        f_vld_q <= 1'b1;
                    end
                end
                PAUSE: begin
                    if (stop) begin
                        state_q <= IDLE;
                        abort_q <= 1'b1;
                        busy_q  <= 1'b0;
                        f_vld_q <= 1'b0;
                    end else if (!pause) begin
                        state_q <= RUN;
                        q_q     <= q_d;
                        cnt_q   <= cnt_d;
                        f_q     <= f_d;
                        f_vld_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    f_vld_q <= 1'b0;
                end
            endcase
        end
    end

    assign f     = f_q;
    assign f_vld = f_vld_q;
    assign q     = q_q;
    assign cnt   = cnt_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign abort = abort_q;

endmodule
